// File: rtl/sudoku_board_ctrl_if.sv
// -----------------------------------------------------------------------------
// sudoku_board_ctrl_if
// RAM-side bus of the sudoku board controller. The board lives in an external
// synchronous-read RAM, one word per row.
//   ram_addr  : row address (controller -> RAM)
//   ram_we    : one-cycle write strobe (controller -> RAM)
//   ram_wdata : write word {wp, blank, digits} (controller -> RAM)
//   ram_rdata : read word, valid one cycle after ram_addr (RAM -> controller)
// -----------------------------------------------------------------------------
interface sudoku_board_ctrl_if #(
  parameter int AW = 2,
  parameter int WW = 24
);
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_rdata;
  logic          ram_we;
  logic [WW-1:0] ram_wdata;

  modport master (
    output ram_addr,
    output ram_we,
    output ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_we,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/sudoku_board_ctrl.sv
// -----------------------------------------------------------------------------
// sudoku_board_ctrl
// Cursor navigation plus fetch/modify/write sequencing for an NxN sudoku board
// held in an external RAM (one word per row, {wp, blank, digits}).
// Ports:
//   clk_i, rst_n_i      : clock, asynchronous active-low reset
//   ram                 : RAM bus (master side), ram_addr always equals row_addr_o
//   user_num_i          : digit to write (legal 1..N)
//   *_btn_i             : navigation levels, edge-detected internally
//   write_req_i         : write user_num_i at the cursor (level, edge-detected)
//   erase_req_i         : clear the cell at the cursor (level, edge-detected)
//   row_addr_o          : displayed row
//   cur_col_o           : one-hot selected column
//   cur_row_o           : digit field of the RAM read word (combinational)
//   busy_o              : command in progress
//   no_write_o          : last command rejected
//   conflict_o          : last accepted write duplicates a digit in the row
// -----------------------------------------------------------------------------
module sudoku_board_ctrl #(
  parameter int N    = 4,
  parameter int DW   = 4,
  parameter int AW   = 2,
  parameter int WRAP = 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  sudoku_board_ctrl_if.master ram,
  input  logic [DW-1:0]       user_num_i,
  input  logic                up_btn_i,
  input  logic                down_btn_i,
  input  logic                left_btn_i,
  input  logic                right_btn_i,
  input  logic                write_req_i,
  input  logic                erase_req_i,
  output logic [AW-1:0]       row_addr_o,
  output logic [N-1:0]        cur_col_o,
  output logic [N*DW-1:0]     cur_row_o,
  output logic                busy_o,
  output logic                no_write_o,
  output logic                conflict_o
);

  localparam int WW = 2*N + N*DW;
  localparam int BB = N*DW;      // base of blank field
  localparam int PB = N*DW + N;  // base of write-protect field

  // Event vector bit positions, highest index = highest priority
  localparam int EV_WR = 5;
  localparam int EV_ER = 4;
  localparam int EV_L  = 3;
  localparam int EV_R  = 2;
  localparam int EV_U  = 1;
  localparam int EV_D  = 0;

  localparam logic [N-1:0]  COL_LSB = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  COL_MSB = {1'b1, {(N-1){1'b0}}};
  localparam logic [AW-1:0] ROW_MAX = AW'(N-1);
  localparam logic [AW-1:0] ROW_ONE = AW'(1);
  localparam logic [AW-1:0] ROW_MIN = {AW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_MODIFY = 2'd2,
    S_WRITE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    prev_q;
  logic [5:0]    lvl_s, ev_s;
  logic [AW-1:0] row_q, row_d;
  logic [N-1:0]  col_q, col_d;
  logic [WW-1:0] buf_q, buf_d;
  logic [WW-1:0] wdata_q, wdata_d;
  logic          nw_q, nw_d;
  logic          cf_q, cf_d;
  logic          is_wr_q, is_wr_d;
  logic [N-1:0]  col_left_s, col_right_s;
  logic [AW-1:0] row_up_s, row_down_s;
  logic [WW-1:0] mod_word_s;
  logic          dup_s, reject_s, cmd_s;
  logic          busy_s, we_s;

  assign lvl_s = {write_req_i, erase_req_i, left_btn_i, right_btn_i, up_btn_i, down_btn_i};
  assign ev_s  = lvl_s & ~prev_q;
  assign cmd_s = ev_s[EV_WR] | ev_s[EV_ER];

  // State register; history resets to 1 so levels held through reset do not fire
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      prev_q  <= 6'b111111;
      row_q   <= ROW_MIN;
      col_q   <= COL_LSB;
      buf_q   <= {WW{1'b0}};
      wdata_q <= {WW{1'b0}};
      nw_q    <= 1'b0;
      cf_q    <= 1'b0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= lvl_s;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      nw_q    <= nw_d;
      cf_q    <= cf_d;
      is_wr_q <= is_wr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_s) state_d = S_FETCH;
        else       state_d = S_IDLE;
      end
      S_FETCH:  state_d = S_MODIFY;
      S_MODIFY: begin
        if (reject_s) state_d = S_IDLE;
        else          state_d = S_WRITE;
      end
      S_WRITE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register, so reset clears them at once
  always_comb begin
    busy_s = 1'b0;
    we_s   = 1'b0;
    case (state_q)
      S_IDLE:   begin busy_s = 1'b0; we_s = 1'b0; end
      S_FETCH:  begin busy_s = 1'b1; we_s = 1'b0; end
      S_MODIFY: begin busy_s = 1'b1; we_s = 1'b0; end
      S_WRITE:  begin busy_s = 1'b1; we_s = 1'b1; end
      default:  begin busy_s = 1'b0; we_s = 1'b0; end
    endcase
  end

  // Cursor and row movement candidates (wrap or saturate at the edges)
  always_comb begin
    if (col_q[N-1]) col_left_s = (WRAP != 0) ? COL_LSB : col_q;
    else            col_left_s = col_q << 1;
    if (col_q[0])   col_right_s = (WRAP != 0) ? COL_MSB : col_q;
    else            col_right_s = col_q >> 1;
    if (row_q == ROW_MIN) row_up_s = (WRAP != 0) ? ROW_MAX : row_q;
    else                  row_up_s = row_q - ROW_ONE;
    if (row_q == ROW_MAX) row_down_s = (WRAP != 0) ? ROW_MIN : row_q;
    else                  row_down_s = row_q + ROW_ONE;
  end

  // Modified row word and duplicate scan over the other non-blank columns
  always_comb begin
    mod_word_s = buf_q;
    dup_s      = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (col_q[j]) begin
        mod_word_s[j*DW +: DW] = is_wr_q ? user_num_i : {DW{1'b0}};
        mod_word_s[BB + j]     = ~is_wr_q;
      end else if (!buf_q[BB + j] && (buf_q[j*DW +: DW] == user_num_i)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
    reject_s = (|(buf_q[PB +: N] & col_q)) |
               (is_wr_q & ((user_num_i == {DW{1'b0}}) || (user_num_i > DW'(N))));
  end

  // Datapath next-state: navigation, command latch, fetch buffer, modify result
  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    nw_d    = nw_q;
    cf_d    = cf_q;
    is_wr_d = is_wr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_s) begin
          is_wr_d = ev_s[EV_WR];
          nw_d    = 1'b0;
          cf_d    = 1'b0;
        end else if (ev_s[EV_L]) begin
          col_d = col_left_s;
        end else if (ev_s[EV_R]) begin
          col_d = col_right_s;
        end else if (ev_s[EV_U]) begin
          row_d = row_up_s;
        end else if (ev_s[EV_D]) begin
          row_d = row_down_s;
        end else begin
          row_d = row_q;
        end
      end
      S_FETCH: buf_d = ram.ram_rdata;
      S_MODIFY: begin
        if (reject_s) begin
          nw_d = 1'b1;
        end else begin
          wdata_d = mod_word_s;
          cf_d    = is_wr_q & dup_s;
        end
      end
      S_WRITE: wdata_d = wdata_q;
      default: wdata_d = wdata_q;
    endcase
  end

  assign ram.ram_addr  = row_q;
  assign ram.ram_we    = we_s;
  assign ram.ram_wdata = wdata_q;
  assign row_addr_o    = row_q;
  assign cur_col_o     = col_q;
  assign cur_row_o     = ram.ram_rdata[N*DW-1:0];
  assign busy_o        = busy_s;
  assign no_write_o    = nw_q;
  assign conflict_o    = cf_q;

endmodule
